// File: rtl/bf16_acc_pkg.sv
// bf16_acc_pkg: opcodes, issue FSM states and the request record shared by the BF16 command stage
package bf16_acc_pkg;
    localparam logic [3:0] OP_B2F = 4'd0, OP_F2B = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
                           OP_MUL = 4'd4, OP_DIV = 4'd5, OP_SQRT = 4'd6, OP_FMADD = 4'd7,
                           OP_FMSUB = 4'd8, OP_FNMADD = 4'd9, OP_FMNSUB = 4'd10;
    localparam logic [3:0] OP_MAX_LEGAL = OP_FMNSUB;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} issue_state_t;
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [3:0]  tag;
    } acc_req_t;
endpackage

// File: rtl/bf16_sync_fifo.sv
// bf16_sync_fifo: power-of-2 synchronous FIFO; the count keeps full and empty apart when the pointers meet
module bf16_sync_fifo
    import bf16_acc_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = acc_req_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  T                       din,
    input  logic                   pop,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    T mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign dout  = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/bf16_acc_cmd_issue.sv
// bf16_acc_cmd_issue: queues host ops and issues them one at a time to the BF16 core, in order.
// Define BF16_ILLEGAL_OP_CHECK_EN to answer opcodes above OP_MAX_LEGAL without enabling the core.
module bf16_acc_cmd_issue
    import bf16_acc_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int MIN_LAT = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [3:0]             req_op,
    input  logic [31:0]            req_a,
    input  logic [31:0]            req_b,
    input  logic [31:0]            req_c,
    input  logic [TAG_W-1:0]       req_tag,
    output logic                   acc_enable,
    output logic [3:0]             acc_operation,
    output logic [31:0]            acc_operand_a,
    output logic [31:0]            acc_operand_b,
    output logic [31:0]            acc_operand_c,
    input  logic [31:0]            acc_result,
    input  logic [3:0]             acc_fpcsr,
    input  logic                   acc_valid,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_result,
    output logic [3:0]             rsp_fpcsr,
    output logic [TAG_W-1:0]       rsp_tag,
    output logic                   rsp_err,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef struct packed {
        logic [3:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [31:0]      c;
        logic [TAG_W-1:0] tag;
    } req_t;
    issue_state_t state, state_d;
    req_t head, iss;
    logic [CW-1:0] cnt;
    logic push, pop, full, empty, ill, ok, tmo;
    assign req_ready = !full;
    assign push      = req_valid && req_ready;
    bf16_sync_fifo #(.DEPTH(DEPTH), .T(req_t)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .din(req_t'{req_op, req_a, req_b, req_c, req_tag}),
        .pop(pop), .dout(head), .full(full), .empty(empty), .count(occupancy)
    );
`ifdef BF16_ILLEGAL_OP_CHECK_EN
    assign ill = head.op > OP_MAX_LEGAL;
`else
    assign ill = 1'b0;
`endif
    assign pop = state == IDLE && !empty;
    // early valids are leftovers from a previous op still draining out of the core
    assign ok  = state == ISSUE && acc_valid && cnt >= CW'(MIN_LAT);
    assign tmo = state == ISSUE && !ok && cnt == CW'(TIMEOUT - 1);
    always_comb begin
        state_d = state;
        state_d = state == IDLE  ? (pop ? (ill ? RESP : ISSUE) : IDLE) :
                  state == ISSUE ? (ok || tmo ? RESP : ISSUE) :
                                   (rsp_ready ? IDLE : RESP);
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_d;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            iss        <= '0;
            cnt        <= '0;
            rsp_result <= '0;
            rsp_fpcsr  <= '0;
            rsp_err    <= 1'b0;
        end else if (pop) begin
            iss        <= head;
            cnt        <= '0;
            rsp_result <= '0;
            rsp_fpcsr  <= ill ? 4'b0001 : 4'b0000;
            rsp_err    <= ill;
        end else if (state == ISSUE) begin
            cnt <= cnt == CW'(TIMEOUT) ? cnt : cnt + 1'b1;
            if (ok) begin
                rsp_result <= acc_result;
                rsp_fpcsr  <= acc_fpcsr;
                rsp_err    <= 1'b0;
            end else if (tmo) begin
                rsp_result <= '0;
                rsp_fpcsr  <= '0;
                rsp_err    <= 1'b1;
            end
        end
    end
    assign acc_enable    = state == ISSUE;
    assign acc_operation = iss.op;
    assign acc_operand_a = iss.a;
    assign acc_operand_b = iss.b;
    assign acc_operand_c = iss.c;
    assign rsp_valid     = state == RESP;
    assign rsp_tag       = iss.tag;
endmodule

// File: tb/tb_bf16_acc_cmd_issue.sv
// tb_bf16_acc_cmd_issue: directed and randomized checks of the BF16 command stage against a transaction model
module tb_bf16_acc_cmd_issue;
    localparam int DEPTH = 4, TAG_W = 4, MIN_LAT = 2, TIMEOUT = 16;
`ifdef BF16_ILLEGAL_OP_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif
    typedef struct {logic [3:0] op; logic [31:0] a, b, c; logic [3:0] tag;} req_t;
    typedef struct {logic [31:0] result; logic [3:0] fpcsr; logic err;} rsp_t;
    logic clk = 1'b0, reset = 1'b1;
    logic req_valid = 1'b0, req_ready, rsp_ready = 1'b0;
    logic [3:0] req_op = '0;
    logic [31:0] req_a = '0, req_b = '0, req_c = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic acc_enable, acc_valid, rsp_valid, rsp_err;
    logic [3:0] acc_operation, acc_fpcsr, rsp_fpcsr;
    logic [31:0] acc_operand_a, acc_operand_b, acc_operand_c, acc_result, rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic [$clog2(DEPTH):0] occupancy;
    req_t req_q[$];
    rsp_t res_q[$];
    int nchk = 0, nerr = 0, npush = 0, nrsp = 0, en_cycles = 0;
    int plan_real = -1, plan_stale = -1;
    always #5 clk = ~clk;
    bf16_acc_cmd_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_tag(req_tag), .acc_enable(acc_enable),
        .acc_operation(acc_operation), .acc_operand_a(acc_operand_a), .acc_operand_b(acc_operand_b),
        .acc_operand_c(acc_operand_c), .acc_result(acc_result), .acc_fpcsr(acc_fpcsr),
        .acc_valid(acc_valid), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_fpcsr(rsp_fpcsr), .rsp_tag(rsp_tag), .rsp_err(rsp_err), .occupancy(occupancy)
    );
    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [31:0] core_res(logic [31:0] s, int k);
        return s + 32'(k) * 32'h0101_0101;
    endfunction
    function automatic logic [3:0] core_fl(logic [31:0] s, int k);
        return s[3:0] ^ 4'(k);
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic send(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [3:0] tag);
        req_t r;
        int n;
        r.op = op; r.a = a; r.b = b; r.c = c; r.tag = tag;
        req_op = op; req_a = a; req_b = b; req_c = c; req_tag = tag; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 300) begin
            step();
            n++;
        end
        chk("push_accepted", req_ready, 1);
        if (req_ready) begin
            req_q.push_back(r);
            npush++;
        end
        step();
        req_valid = 1'b0;
    endtask
    task automatic drain(string tag);
        int n = 0;
        while ((req_q.size() != 0 || rsp_valid || acc_enable) && n < 3000) begin
            step();
            n++;
        end
        chk({tag, "_drained"}, n < 3000, 1);
    endtask
    // core model: per issue, valid may pulse early (must be ignored) and once at real_k
    initial begin : core
        int k, real_k, exp_len, found;
        bit stale;
        logic [31:0] seed;
        rsp_t e;
        k = 0; real_k = 0; exp_len = 0; stale = 0; seed = '0;
        acc_valid = 1'b0; acc_result = '0; acc_fpcsr = '0;
        forever begin
            step();
            if (reset) k = 0;
            else if (acc_enable) begin
                if (k == 0) begin
                    seed   = $urandom;
                    real_k = plan_real >= 0 ? plan_real : int'($urandom_range(TIMEOUT + 3));
                    stale  = plan_stale >= 0 ? plan_stale[0] : 1'($urandom % 2);
                    found  = (real_k >= MIN_LAT && real_k < TIMEOUT) ? real_k : -1;
                    exp_len = found >= 0 ? found + 1 : TIMEOUT;
                    e.result = found >= 0 ? core_res(seed, found) : 32'h0;
                    e.fpcsr  = found >= 0 ? core_fl(seed, found) : 4'h0;
                    e.err    = found < 0;
                    res_q.push_back(e);
                    chk("issue_has_req", req_q.size() != 0, 1);
                    if (req_q.size() != 0) begin
                        chk("iss_op", acc_operation, req_q[0].op);
                        chk("iss_a", acc_operand_a, req_q[0].a);
                        chk("iss_b", acc_operand_b, req_q[0].b);
                        chk("iss_c", acc_operand_c, req_q[0].c);
                    end
                end
                acc_valid  = (k == real_k) || (stale && k < MIN_LAT);
                acc_result = core_res(seed, k);
                acc_fpcsr  = core_fl(seed, k);
                en_cycles++;
                k++;
            end else begin
                if (k > 0) chk("en_len", k, exp_len);
                k = 0;
                acc_valid  = 1'($urandom % 2);
                acc_result = $urandom;
                acc_fpcsr  = 4'($urandom);
            end
        end
    end
    initial begin : rsp_chk
        req_t r;
        rsp_t e;
        bit have;
        forever begin
            @(negedge clk);
            if (acc_enable) chk("en_rsp_excl", rsp_valid, 0);
            if (!reset && rsp_valid && rsp_ready) begin
                nrsp++;
                chk("rsp_has_req", req_q.size() != 0, 1);
                if (req_q.size() != 0) begin
                    r = req_q.pop_front();
                    have = 1'b1;
                    if (ILL_EN && r.op > 4'd10) begin
                        e.result = '0; e.fpcsr = 4'b0001; e.err = 1'b1;
                    end else begin
                        chk("rsp_was_issued", res_q.size() != 0, 1);
                        have = res_q.size() != 0;
                        if (have) e = res_q.pop_front();
                    end
                    if (have) begin
                        chk("rsp_tag", rsp_tag, r.tag);
                        chk("rsp_result", rsp_result, e.result);
                        chk("rsp_fpcsr", rsp_fpcsr, e.fpcsr);
                        chk("rsp_err", rsp_err, e.err);
                    end
                end
            end
        end
    end
    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end
    initial begin : main
        int base;
        step();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_en", acc_enable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_tag", rsp_tag, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_op", acc_operation, 0);
        step();
        reset = 1'b0;
        step();
        // basic latency: push edge 0, issue edge 1, response edge 1+MIN_LAT+1
        rsp_ready = 1'b1; plan_real = MIN_LAT; plan_stale = 0;
        send(4'd4, 32'h3F80_0000, 32'h4000_0000, 32'h0, 4'd3);
        chk("t1_occ", occupancy, 1);
        chk("t1_en_pre", acc_enable, 0);
        step();
        chk("t1_en", acc_enable, 1);
        chk("t1_op", acc_operation, 4);
        chk("t1_occ_popped", occupancy, 0);
        repeat (MIN_LAT) begin
            step();
            chk("t1_en_hold", acc_enable, 1);
            chk("t1_rsp_early", rsp_valid, 0);
        end
        step();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_tag", rsp_tag, 3);
        chk("t1_en_off", acc_enable, 0);
        drain("t1");
        // stale valids before MIN_LAT must not be captured
        plan_stale = 1;
        send(4'd2, 32'h1234_5678, 32'h9abc_def0, 32'h1, 4'd7);
        drain("t5");
        // timeout, then a normal op
        plan_stale = 0; plan_real = TIMEOUT + 4;
        send(4'd7, 32'h1, 32'h2, 32'h3, 4'd9);
        drain("t4");
        plan_real = TIMEOUT - 1;
        send(4'd3, 32'h5, 32'h6, 32'h7, 4'd10);
        drain("t4_edge");
        plan_real = -1; plan_stale = -1;
        for (int i = 0; i < 4; i++) send(4'(i + 1), $urandom, $urandom, $urandom, 4'(i));
        drain("t2");
        // fill the FIFO behind a blocked response
        base = nrsp;
        rsp_ready = 1'b0; plan_real = MIN_LAT;
        for (int i = 0; i < DEPTH + 1; i++) send(4'd5, $urandom, $urandom, 32'(i), 4'(i));
        req_op = 4'd6; req_a = 32'hA; req_b = 32'hB; req_c = 32'hC; req_tag = 4'd11; req_valid = 1'b1;
        repeat (3) begin
            step();
            chk("t3_ready_low", req_ready, 0);
            chk("t3_occ_full", occupancy, DEPTH);
        end
        rsp_ready = 1'b1;
        send(4'd6, 32'hA, 32'hB, 32'hC, 4'd11);
        drain("t3");
        chk("t3_count", nrsp - base, DEPTH + 2);
        // reset with one op in flight and two queued
        plan_real = TIMEOUT + 4;
        for (int i = 0; i < 3; i++) send(4'd8, $urandom, $urandom, $urandom, 4'(12 + i));
        chk("t6_pre_en", acc_enable, 1);
        chk("t6_pre_occ", occupancy, 2);
        reset = 1'b1;
        step();
        chk("t6_en", acc_enable, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_occ", occupancy, 0);
        chk("t6_ready", req_ready, 1);
        req_q.delete();
        res_q.delete();
        step();
        reset = 1'b0;
        plan_real = -1;
`ifdef BF16_ILLEGAL_OP_CHECK_EN
        base = en_cycles;
        send(4'hF, 32'h1, 32'h2, 32'h3, 4'd5);
        drain("t6_ill");
        chk("t6_ill_no_enable", en_cycles - base, 0);
`endif
        base = nrsp;
        npush = 0;
        for (int i = 0; i < 1500; i++) begin
            rsp_ready = ($urandom % 4) != 0;
            req_valid = ($urandom % 3) == 0;
            req_op = 4'($urandom); req_a = $urandom; req_b = $urandom; req_c = $urandom;
            req_tag = 4'($urandom);
            if (req_valid && req_ready) begin
                req_q.push_back('{req_op, req_a, req_b, req_c, req_tag});
                npush++;
            end
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain("rand");
        chk("rand_rsp_count", nrsp - base, npush);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
